fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 resetn  input  1  reset, asynchronous, active-low.
REQ-003 stall  input  1  downstream cannot accept a fetched instruction this cycle.
REQ-004 ex_req / eret_req / br_req / j_req / jr_req  input  1 each  redirect requests, single-cycle pulses.
REQ-005 inst_addr_ok / inst_data_ok  input  1 each  instruction SRAM address accepted / data returned.
REQ-006 inst_req  output  1  instruction SRAM request.
REQ-007 pc_write  output  1  one-cycle pulse that advances the PC register.
REQ-008 pc_src  output  2  next-PC select: 00 sequential, 01 jump, 10 branch; 11 never driven.
REQ-009 j_src  output  1  jump target select: 1 register target, 0 immediate target.
REQ-010 ex_sel / eret_sel  output  1 each  force exception vector / EPC as next PC.
REQ-011 if_valid  output  1  fetched instruction is valid for decode.

Function
REQ-012 FSM states SHALL be RST_IDLE, REQ, WAIT, HOLD.
REQ-013 RST_IDLE: all outputs 0; SHALL go to REQ on the next edge unconditionally.
REQ-014 REQ: inst_req=1; SHALL go to WAIT on inst_addr_ok=1, else stay.
REQ-015 WAIT: on inst_data_ok with stall=0, pc_write=1 and go to REQ; with stall=1, go to HOLD; with no data_ok, stay.
REQ-016 HOLD: if_valid=1; when stall=0, pc_write=1 and go to REQ.
REQ-017 if_valid SHALL be 1 in the WAIT cycle where inst_data_ok=1 and in every HOLD cycle, unless the discard flag is set.
REQ-018 Redirect priority SHALL be ex > eret > br > jr > j; only the highest pending request is retained.
REQ-019 A redirect not coinciding with pc_write SHALL be latched into a pending register; a later request overwrites it only if of equal or higher priority.
REQ-020 A redirect coinciding with pc_write SHALL be applied in that cycle (bypass); the pending register stays empty.
REQ-021 In the pc_write cycle, select outputs SHALL reflect the winning redirect: ex -> ex_sel=1; eret -> eret_sel=1; br -> pc_src=10; jr -> pc_src=01, j_src=1; j -> pc_src=01, j_src=0; none -> pc_src=00.
REQ-022 Select outputs SHALL be 0 outside pc_write cycles; the pending register clears on the pc_write that consumes it.
REQ-023 ex or eret accepted while in WAIT or HOLD SHALL set the discard flag; the discard flag forces if_valid=0 and clears on the next pc_write.
REQ-024 br/j/jr SHALL NOT set the discard flag (delay-slot instruction retained).
REQ-025 inst_data_ok in RST_IDLE or REQ SHALL be ignored.
REQ-026 pc_write SHALL be 0 in RST_IDLE and REQ.

Reset
REQ-027 On resetn=0, asynchronously: state=RST_IDLE, pending register empty, discard flag=0, all outputs 0.
REQ-028 Reset asserted mid-fetch SHALL abandon the outstanding access; no pc_write SHALL follow.

Structure
REQ-029 The shared package SHALL hold state encodings, the pc_src codes (SEQ/JMP/BR), and the redirect priority enum.
REQ-030 The priority select and pending latch SHALL be one sub-module, redir_arb; the FSM resides in fetch_ctrl.

Verification
REQ-031 Release reset; addr_ok in cycle 2, data_ok in cycle 4, stall=0 -> inst_req cycles 1-2, if_valid=1 and pc_write=1 in cycle 4, pc_src=00.
REQ-032 data_ok with stall=1 for 3 cycles -> HOLD; if_valid=1 for 3 cycles; pc_write in the cycle after stall drops.
REQ-033 br_req in REQ, then j_req in WAIT -> pc_write cycle shows pc_src=10; pending empty afterwards.
REQ-034 jr_req in the same cycle as ex_req during WAIT -> ex_sel=1 at pc_write, pc_src=00, if_valid=0 for that return.
REQ-035 eret_req coincident with pc_write -> eret_sel=1 in that same cycle; the next pc_write has pc_src=00.
REQ-036 resetn=0 in WAIT, then data_ok after release -> no if_valid, no pc_write until a fresh REQ/addr_ok/data_ok sequence.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state
// encodings, next-PC select codes and the redirect priority ordering.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RST_IDLE = 2'b00,
        REQ      = 2'b01,
        WAIT     = 2'b10,
        HOLD     = 2'b11
    } fetch_state_e;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_JMP = 2'b01;
    localparam logic [1:0] PC_SRC_BR  = 2'b10;

    // Numeric order is the priority order, so a plain magnitude compare
    // picks the more important redirect.
    typedef enum logic [2:0] {
        RD_NONE = 3'd0,
        RD_J    = 3'd1,
        RD_JR   = 3'd2,
        RD_BR   = 3'd3,
        RD_ERET = 3'd4,
        RD_EX   = 3'd5
    } redir_e;

    // Reduce the simultaneous request pulses to the single highest one.
    function automatic redir_e redir_encode(input logic ex, input logic eret,
                                            input logic br, input logic jr,
                                            input logic j);
        if (ex)   return RD_EX;
        if (eret) return RD_ERET;
        if (br)   return RD_BR;
        if (jr)   return RD_JR;
        if (j)    return RD_J;
        return RD_NONE;
    endfunction

endpackage

// File: rtl/fetch_ctrl_redir_arb.sv
// Redirect arbiter: keeps the highest-priority redirect seen since the
// last PC update and presents the overall winner (pending vs. incoming).
module redir_arb
    import fetch_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   resetn,
    input  logic   ex_req_i,
    input  logic   eret_req_i,
    input  logic   br_req_i,
    input  logic   jr_req_i,
    input  logic   j_req_i,
    input  logic   apply_i,
    output redir_e win_o
);

    redir_e in_win;
    redir_e pend_q;
    redir_e pend_d;

    // Highest request arriving this cycle.
    always_comb begin
        in_win = redir_encode(ex_req_i, eret_req_i, br_req_i, jr_req_i, j_req_i);
    end

    // Winner is the more important of the retained and the incoming redirect,
    // which lets a same-cycle request bypass straight into a PC update.
    always_comb begin
        win_o = (in_win > pend_q) ? in_win : pend_q;
    end

    // Pending latch: emptied by the PC update that uses it, otherwise
    // overwritten only by an equal or higher priority request.
    always_comb begin
        pend_d = pend_q;
        if (apply_i) begin
            pend_d = RD_NONE;
        end else if ((in_win != RD_NONE) && (in_win >= pend_q)) begin
            pend_d = in_win;
        end
    end

    // Pending register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= RD_NONE;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences SRAM request/response, holds a
// fetched instruction while downstream stalls, and steers the next PC.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       stall,
    input  logic       ex_req,
    input  logic       eret_req,
    input  logic       br_req,
    input  logic       j_req,
    input  logic       jr_req,
    input  logic       inst_addr_ok,
    input  logic       inst_data_ok,
    output logic       inst_req,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       j_src,
    output logic       ex_sel,
    output logic       eret_sel,
    output logic       if_valid
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         discard_q;
    logic         discard_d;
    redir_e       win;

    redir_arb u_redir_arb (
        .clk        (clk),
        .resetn     (resetn),
        .ex_req_i   (ex_req),
        .eret_req_i (eret_req),
        .br_req_i   (br_req),
        .jr_req_i   (jr_req),
        .j_req_i    (j_req),
        .apply_i    (pc_write),
        .win_o      (win)
    );

    // Fetch FSM next state and handshake outputs.
    always_comb begin
        state_d  = state_q;
        inst_req = 1'b0;
        pc_write = 1'b0;
        if_valid = 1'b0;
        case (state_q)
            RST_IDLE: state_d = REQ;
            REQ: begin
                inst_req = 1'b1;
                if (inst_addr_ok) state_d = WAIT;
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if_valid = !discard_q;
                    if (!stall) begin
                        pc_write = 1'b1;
                        state_d  = REQ;
                    end else begin
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if_valid = !discard_q;
                if (!stall) begin
                    pc_write = 1'b1;
                    state_d  = REQ;
                end
            end
            default: state_d = RST_IDLE;
        endcase
    end

    // Discard flag: an exception/return while a fetch is outstanding kills
    // that instruction; the PC update that follows starts clean.
    always_comb begin
        discard_d = discard_q;
        if (pc_write) begin
            discard_d = 1'b0;
        end else if ((ex_req || eret_req) && ((state_q == WAIT) || (state_q == HOLD))) begin
            discard_d = 1'b1;
        end
    end

    // Next-PC selects, only meaningful while the PC is being written.
    always_comb begin
        pc_src   = PC_SRC_SEQ;
        j_src    = 1'b0;
        ex_sel   = 1'b0;
        eret_sel = 1'b0;
        if (pc_write) begin
            case (win)
                RD_EX:   ex_sel   = 1'b1;
                RD_ERET: eret_sel = 1'b1;
                RD_BR:   pc_src   = PC_SRC_BR;
                RD_JR: begin
                    pc_src = PC_SRC_JMP;
                    j_src  = 1'b1;
                end
                RD_J:    pc_src   = PC_SRC_JMP;
                default: pc_src   = PC_SRC_SEQ;
            endcase
        end
    end

    // State and discard registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RST_IDLE;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl: stimulus pushes the expected
// PC-update / valid events, a monitor pops and compares them.
module tb_fetch_ctrl;

    typedef struct packed {
        logic       pw;
        logic       iv;
        logic [1:0] src;
        logic       js;
        logic       exs;
        logic       ers;
    } ev_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       stall, ex_req, eret_req, br_req, j_req, jr_req;
    logic       inst_addr_ok, inst_data_ok;
    logic       inst_req, pc_write, j_src, ex_sel, eret_sel, if_valid;
    logic [1:0] pc_src;

    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t exp_q[$];

    fetch_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall        (stall),
        .ex_req       (ex_req),
        .eret_req     (eret_req),
        .br_req       (br_req),
        .j_req        (j_req),
        .jr_req       (jr_req),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_req     (inst_req),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .j_src        (j_src),
        .ex_sel       (ex_sel),
        .eret_sel     (eret_sel),
        .if_valid     (if_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    task automatic expect_ev(input logic pw, input logic iv, input logic [1:0] src,
                             input logic js, input logic exs, input logic ers);
        ev_t e;
        e = '{pw: pw, iv: iv, src: src, js: js, exs: exs, ers: ers};
        exp_q.push_back(e);
    endtask

    // rq = {ex, eret, br, jr, j}; inputs hold for one cycle
    task automatic cyc(input logic aok, input logic dok, input logic st, input logic [4:0] rq);
        inst_addr_ok = aok;
        inst_data_ok = dok;
        stall        = st;
        {ex_req, eret_req, br_req, jr_req, j_req} = rq;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every PC update or valid instruction must match the next expected event.
    initial begin
        ev_t got;
        ev_t e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1) begin
                if (!pc_write && ({pc_src, j_src, ex_sel, eret_sel} != 5'b0)) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sel_outside_pcwrite got=%b required=00000",
                             {pc_src, j_src, ex_sel, eret_sel});
                end
                if (pc_write || if_valid) begin
                    got = '{pw: pc_write, iv: if_valid, src: pc_src, js: j_src,
                            exs: ex_sel, ers: eret_sel};
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_event got=%b required=none", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            n_bad++;
                            $display("FAIL event got=%b required=%b (pw iv src js exs ers) at %0t",
                                     got, e, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        {inst_addr_ok, inst_data_ok, stall, ex_req, eret_req, br_req, jr_req, j_req} = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_outputs", {1'b0, inst_req, pc_write, pc_src, j_src, ex_sel, eret_sel, if_valid}, 8'h00);

        // basic fetch: release, REQ, REQ+addr_ok, WAIT, WAIT+data_ok
        resetn = 1'b1;
        check("idle_inst_req", {7'b0, inst_req}, 8'd0);
        cyc(0, 0, 0, 5'b00000);
        check("c1_inst_req", {7'b0, inst_req}, 8'd1);
        cyc(0, 0, 0, 5'b00000);
        check("c2_inst_req", {7'b0, inst_req}, 8'd1);
        cyc(1, 0, 0, 5'b00000);
        check("c3_wait_inst_req", {7'b0, inst_req}, 8'd0);
        cyc(0, 0, 0, 5'b00000);
        expect_ev(1, 1, 2'b00, 0, 0, 0);
        cyc(0, 1, 0, 5'b00000);

        // stall hold: three stalled valid cycles then release
        cyc(1, 0, 0, 5'b00000);
        expect_ev(0, 1, 2'b00, 0, 0, 0);
        cyc(0, 1, 1, 5'b00000);
        expect_ev(0, 1, 2'b00, 0, 0, 0);
        cyc(0, 0, 1, 5'b00000);
        expect_ev(0, 1, 2'b00, 0, 0, 0);
        cyc(0, 0, 1, 5'b00000);
        expect_ev(1, 1, 2'b00, 0, 0, 0);
        cyc(0, 0, 0, 5'b00000);

        // br pending in REQ, lower j in WAIT does not override
        cyc(1, 0, 0, 5'b00100);
        cyc(0, 0, 0, 5'b00001);
        expect_ev(1, 1, 2'b10, 0, 0, 0);
        cyc(0, 1, 0, 5'b00000);
        cyc(1, 0, 0, 5'b00000);
        expect_ev(1, 1, 2'b00, 0, 0, 0);
        cyc(0, 1, 0, 5'b00000);

        // ex + jr together in WAIT: ex wins, instruction discarded
        cyc(1, 0, 0, 5'b00000);
        cyc(0, 0, 0, 5'b10010);
        expect_ev(1, 0, 2'b00, 0, 1, 0);
        cyc(0, 1, 0, 5'b00000);
        cyc(1, 0, 0, 5'b00000);
        expect_ev(1, 1, 2'b00, 0, 0, 0);
        cyc(0, 1, 0, 5'b00000);

        // eret bypass in the pc_write cycle
        cyc(1, 0, 0, 5'b00000);
        expect_ev(1, 1, 2'b00, 0, 0, 1);
        cyc(0, 1, 0, 5'b01000);
        cyc(1, 0, 0, 5'b00000);
        expect_ev(1, 1, 2'b00, 0, 0, 0);
        cyc(0, 1, 0, 5'b00000);

        // jr pending, then j bypass
        cyc(1, 0, 0, 5'b00010);
        expect_ev(1, 1, 2'b01, 1, 0, 0);
        cyc(0, 1, 0, 5'b00000);
        cyc(1, 0, 0, 5'b00000);
        expect_ev(1, 1, 2'b01, 0, 0, 0);
        cyc(0, 1, 0, 5'b00001);

        // eret before data: stalled return is invisible, HOLD release applies eret
        cyc(1, 0, 0, 5'b00000);
        cyc(0, 0, 0, 5'b01000);
        cyc(0, 1, 1, 5'b00000);
        expect_ev(1, 0, 2'b00, 0, 0, 1);
        cyc(0, 0, 0, 5'b00000);

        // data_ok while in REQ is ignored
        cyc(0, 1, 0, 5'b00000);
        cyc(1, 0, 0, 5'b00000);
        expect_ev(1, 1, 2'b00, 0, 0, 0);
        cyc(0, 1, 0, 5'b00000);

        // reset mid-fetch with br pending; late data_ok must not complete anything
        cyc(1, 0, 0, 5'b00100);
        resetn = 1'b0;
        #1;
        check("midrst_outputs", {1'b0, inst_req, pc_write, pc_src, j_src, ex_sel, eret_sel, if_valid}, 8'h00);
        cyc(0, 0, 0, 5'b00000);
        resetn = 1'b1;
        check("post_rst_idle_req", {7'b0, inst_req}, 8'd0);
        cyc(0, 1, 0, 5'b00000);
        check("post_rst_req", {7'b0, inst_req}, 8'd1);
        cyc(0, 1, 0, 5'b00000);
        cyc(1, 0, 0, 5'b00000);
        cyc(0, 0, 0, 5'b00000);
        expect_ev(1, 1, 2'b00, 0, 0, 0);
        cyc(0, 1, 0, 5'b00000);

        cyc(0, 0, 0, 5'b00000);
        cyc(0, 0, 0, 5'b00000);
        check("leftover_expected", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
